// File: rtl/avmm_cmd_master.sv
// Avalon-MM initiator: buffers read/write commands in a small FIFO and issues each as a
// single Avalon transfer with waitrequest, fixed read latency and stall timeout.
module avmm_cmd_master #(
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              write_n,
  output logic              read_n,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  input  logic              waitrequest,
  output logic              busy
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned EntW    = 1 + ADDR_W + DATA_W;
  localparam int unsigned LatLast = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;

  localparam logic [PtrW:0] FullCnt     = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [15:0]   StallLast   = 16'(TIMEOUT - 1);
  localparam logic [1:0]    LatLastBits = 2'(LatLast);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRd, StResp} state_e;

  // Command FIFO
  logic [EntW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            fifo_full, fifo_empty, push, pop;
  logic [EntW-1:0] head;
  logic            head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign fifo_full  = (count_q == FullCnt);
  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;

  assign head       = fifo_mem[rd_ptr_q];
  assign head_write = head[EntW-1];
  assign head_addr  = head[EntW-2 -: ADDR_W];
  assign head_data  = head[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {cmd_write, cmd_address, cmd_writedata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Transfer FSM
  state_e            state_q, state_d;
  logic [15:0]       stall_q, stall_d;
  logic [1:0]        lat_q, lat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cs_q, cs_d, write_n_q, write_n_d, read_n_q, read_n_d;
  logic              is_write_q, is_write_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  always_comb begin
    state_d     = state_q;
    stall_d     = stall_q;
    lat_d       = lat_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cs_d        = cs_q;
    write_n_d   = write_n_q;
    read_n_d    = read_n_q;
    is_write_d  = is_write_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          is_write_d = head_write;
          addr_d     = head_addr;
          wdata_d    = head_data;
          cs_d       = 1'b1;
          write_n_d  = !head_write;
          read_n_d   = head_write;
          stall_d    = '0;
          lat_d      = '0;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (!waitrequest) begin
          cs_d      = 1'b0;
          write_n_d = 1'b1;
          read_n_d  = 1'b1;
          if (is_write_q) begin
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b0;
            state_d     = StResp;
          end else if (READ_LATENCY == 0) begin
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b0;
            rsp_data_d  = readdata;
            rsp_err_d   = 1'b0;
            state_d     = StResp;
          end else begin
            state_d = StWaitRd;
          end
        end else if (stall_q == StallLast) begin
          // This edge is the TIMEOUT-th stalled cycle: give up on the slave
          cs_d        = 1'b0;
          write_n_d   = 1'b1;
          read_n_d    = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_write_d = is_write_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = StResp;
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end
      StWaitRd: begin
        if (lat_q == LatLastBits) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_data_d  = readdata;
          rsp_err_d   = 1'b0;
          state_d     = StResp;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      stall_q     <= '0;
      lat_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cs_q        <= 1'b0;
      write_n_q   <= 1'b1;
      read_n_q    <= 1'b1;
      is_write_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_q     <= stall_d;
      lat_q       <= lat_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cs_q        <= cs_d;
      write_n_q   <= write_n_d;
      read_n_q    <= read_n_d;
      is_write_q  <= is_write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign address      = addr_q;
  assign writedata    = wdata_q;
  assign chipselect   = cs_q;
  assign write_n      = write_n_q;
  assign read_n       = read_n_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_write    = rsp_write_q;
  assign rsp_readdata = rsp_data_q;
  assign rsp_error    = rsp_err_q;
  assign busy         = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_avmm_cmd_master.sv
// Bench for avmm_cmd_master: directed scenarios plus random traffic against a slave memory
// and an in-order response model.
module tb_avmm_cmd_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_write;
  logic        cmd_ready;
  logic [1:0]  cmd_address;
  logic [31:0] cmd_writedata;
  logic        rsp_valid, rsp_write, rsp_error;
  logic [31:0] rsp_readdata;
  logic [1:0]  address;
  logic        chipselect, write_n, read_n;
  logic [31:0] writedata;
  logic [31:0] readdata = 32'h0;
  logic        waitrequest = 1'b0;
  logic        busy;

  avmm_cmd_master #(
    .ADDR_W(2), .DATA_W(32), .FIFO_DEPTH(4), .READ_LATENCY(1), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_readdata(rsp_readdata),
    .rsp_error(rsp_error),
    .address(address), .chipselect(chipselect), .write_n(write_n), .read_n(read_n),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Slave behaviour: 0 never stall, 1 random short stalls, 2 stuck, 3 stall stall_target cycles
  int          wr_mode = 0;
  int          stall_target = 0;
  logic [31:0] smem [4] = '{default: 32'h0};
  logic [31:0] ref_mem [4] = '{default: 32'h0};
  logic [33:0] exp_q [$];
  int          bus_writes = 0;
  int          n_rsp = 0;
  int          cs_run = 0;
  int          last_run = 0;
  int          stall_run = 0;
  logic        rd_pend = 1'b0;
  logic [1:0]  rd_addr = 2'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      waitrequest = 1'b0;
      rd_pend     = 1'b0;
      cs_run      = 0;
      stall_run   = 0;
    end else begin
      if (rd_pend) begin
        readdata = smem[rd_addr];
        rd_pend  = 1'b0;
      end else begin
        readdata = $urandom();
      end
      if (chipselect) begin
        case (wr_mode)
          0:       waitrequest = 1'b0;
          1:       waitrequest = (stall_run < 3) && ($urandom_range(0, 2) == 0);
          2:       waitrequest = 1'b1;
          default: waitrequest = (stall_run < stall_target);
        endcase
        if (waitrequest) stall_run++;
        else stall_run = 0;
        if (!waitrequest && !write_n) begin
          smem[address] = writedata;
          bus_writes++;
        end
        if (!waitrequest && !read_n) begin
          rd_pend = 1'b1;
          rd_addr = address;
        end
        cs_run++;
      end else begin
        waitrequest = 1'($urandom_range(0, 1));
        if (cs_run > 0) last_run = cs_run;
        cs_run    = 0;
        stall_run = 0;
      end
      if (rsp_valid) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 1'b0);
        end else begin
          check("rsp_content", {rsp_write, rsp_error, rsp_readdata}, exp_q.pop_front());
        end
      end
    end
  end

  // Push one command; the model records the response it must produce.
  task automatic send(input logic w, input logic [1:0] a, input logic [31:0] d,
                      input logic err);
    int n = 0;
    cmd_valid     = 1'b1;
    cmd_write     = w;
    cmd_address   = a;
    cmd_writedata = d;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", cmd_ready, 1'b1);
    if (err) exp_q.push_back({w, 1'b1, 32'h0});
    else if (w) begin
      ref_mem[a] = d;
      exp_q.push_back({2'b10, 32'h0});
    end else exp_q.push_back({2'b00, ref_mem[a]});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (busy || exp_q.size() != 0); i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_busy", busy, 1'b0);
    check("drain_queue", exp_q.size(), 0);
  endtask

  int          rsp0, bw0;
  logic [31:0] d;

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 2'd0; cmd_writedata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus", {chipselect, write_n, read_n, address, writedata}, {3'b011, 34'h0});
    check("rst_rsp", {rsp_valid, rsp_write, rsp_error, rsp_readdata}, 35'h0);
    check("rst_busy_ready", {busy, cmd_ready}, 2'b01);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single write, no stall
    wr_mode = 0;
    send(1'b1, 2'd0, 32'h1, 1'b0);
    check("t1_idle", chipselect, 1'b0);
    @(posedge clk); #1;
    check("t1_bus", {chipselect, write_n, read_n, address, writedata}, {3'b101, 2'd0, 32'h1});
    @(posedge clk); #1;
    check("t1_drop", {chipselect, write_n, read_n}, 3'b011);
    check("t1_rsp", {rsp_valid, rsp_write, rsp_error}, 3'b110);
    @(posedge clk); #1;
    check("t1_once", {rsp_valid, busy, rsp_write}, 3'b001);

    // Read with one cycle of latency
    send(1'b0, 2'd0, 32'hDEAD_BEEF, 1'b0);
    check("t2_idle", chipselect, 1'b0);
    @(posedge clk); #1;
    check("t2_bus", {chipselect, write_n, read_n, address}, {3'b110, 2'd0});
    @(posedge clk); #1;
    check("t2_wait", {chipselect, rsp_valid}, 2'b00);
    @(posedge clk); #1;
    check("t2_rsp", {rsp_valid, rsp_write, rsp_error, rsp_readdata}, {3'b100, 32'h1});
    @(posedge clk); #1;

    // Write stalled three cycles
    wr_mode = 3; stall_target = 3; bw0 = bus_writes; d = $urandom();
    send(1'b1, 2'd2, d, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check("t3_hold", {chipselect, write_n, read_n, address, writedata}, {3'b101, 2'd2, d});
      @(posedge clk); #1;
    end
    check("t3_rsp", {chipselect, rsp_valid}, 2'b01);
    @(posedge clk); #1;
    check("t3_one_write", bus_writes - bw0, 1);

    // Timeout on a read while four more commands fill the FIFO
    wr_mode = 2; rsp0 = n_rsp;
    send(1'b0, 2'd1, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) send(1'($urandom_range(0, 1)), 2'(i), $urandom(), 1'b0);
    check("t5_full", cmd_ready, 1'b0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 2'd3; cmd_writedata = 32'hBAD0_0005;
    repeat (2) begin
      @(posedge clk); #1;
      check("t5_blocked", cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 40 && !rsp_valid; i++) begin
      @(posedge clk); #1;
    end
    check("t4_rsp", {rsp_valid, rsp_write, rsp_error, rsp_readdata}, {3'b101, 32'h0});
    wr_mode = 1;
    @(negedge clk); #1;
    check("t4_run", last_run, 8);
    drain();
    check("t5_count", n_rsp - rsp0, 5);

    // Reset while a read is being issued with another read queued
    wr_mode = 2;
    send(1'b0, 2'd2, 32'h0, 1'b0);
    send(1'b0, 2'd3, 32'h0, 1'b0);
    check("t6_issue", {chipselect, read_n}, 2'b10);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("t6_bus", {chipselect, write_n, read_n, address, writedata}, {3'b011, 34'h0});
    check("t6_rsp", {rsp_valid, rsp_write, rsp_error, rsp_readdata}, 35'h0);
    check("t6_busy_ready", {busy, cmd_ready}, 2'b01);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wr_mode = 0; rsp0 = n_rsp;
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("t6_no_rsp", n_rsp - rsp0, 0);
    check("t6_empty", busy, 1'b0);

    // Random traffic
    wr_mode = 1; rsp0 = n_rsp;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom(), 1'b0);
    end
    drain();
    check("rand_count", n_rsp - rsp0, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
